gauss_window_ctrl: RTL

Front-end sequencer for the 3x3 Gaussian window datapath. Accepts a raster-order RGB pixel stream and uses two internal ping-pong line buffers to produce three vertically aligned rows per pixel (line r-2, r-1, r). These feed the matrix block's din1/din2/din3, with a qualifying valid that drives its valid_in. It also tracks frame position, suppresses windows until two full lines are buffered, and flags frame completion.

---
 rtl/gauss_window_ctrl_if.sv | 30 +++
 rtl/gauss_window_ctrl.sv | 139 +++++++++++++
 2 files changed

// File: rtl/gauss_window_ctrl_if.sv
// Pixel-stream and window-output bundle for the 3x3 Gaussian front-end sequencer.
// master drives the pixel stream; slave (the sequencer) returns the aligned rows.
interface gauss_window_ctrl_if #(
    parameter int WIDTH = 24
);
    // Handshake: a pixel transfers on any rising edge where pix_valid=1; there is no
    // ready, so the sequencer consumes or drops it in that cycle. win_valid qualifies
    // row_* for exactly one cycle and has no backpressure either.
    logic             sof;
    logic             pix_valid;
    logic [WIDTH-1:0] pix_data;
    logic [WIDTH-1:0] row_top;
    logic [WIDTH-1:0] row_mid;
    logic [WIDTH-1:0] row_bot;
    logic             win_valid;
    logic             line_last;
    logic             frame_done;
    logic             busy;
    logic [1:0]       dbg_state;

    modport master (
        output sof, pix_valid, pix_data,
        input  row_top, row_mid, row_bot, win_valid, line_last, frame_done, busy, dbg_state
    );

    modport slave (
        input  sof, pix_valid, pix_data,
        output row_top, row_mid, row_bot, win_valid, line_last, frame_done, busy, dbg_state
    );
endinterface

// File: rtl/gauss_window_ctrl.sv
// Raster-stream sequencer: two ping-pong line buffers turn a pixel stream into
// vertically aligned rows (r-2, r-1, r) for the 3x3 Gaussian matrix block.
module gauss_window_ctrl #(
    parameter int PIC_WIDTH  = 250,
    parameter int PIC_HEIGHT = 250,
    parameter int WIDTH      = 24
) (
    input  logic               clk,
    input  logic               rst,
    gauss_window_ctrl_if.slave bus
);
    localparam int CW = (PIC_WIDTH > 1) ? $clog2(PIC_WIDTH) : 1;
    localparam int RW = (PIC_HEIGHT > 1) ? $clog2(PIC_HEIGHT) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(PIC_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(PIC_HEIGHT - 1);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    col_q;
    logic [RW-1:0]    row_q;
    logic             wsel_q;
    logic [WIDTH-1:0] top_q, mid_q, bot_q;
    logic             win_q, last_q, done_q, busy_q;

    logic [WIDTH-1:0] lb0 [PIC_WIDTH];
    logic [WIDTH-1:0] lb1 [PIC_WIDTH];

    logic             accept, restart;
    logic [CW-1:0]    cur_col;
    logic [RW-1:0]    cur_row;
    logic             cur_wsel;
    logic             col_wrap, frame_end;
    logic             win_d, last_d, done_d;
    logic [WIDTH-1:0] top_rd, mid_rd;

    // A sof pixel is position (0,0) with wsel cleared, so the current pixel's
    // position and bank are resolved before the counters are touched.
    always_comb begin
        accept    = bus.pix_valid && (bus.sof || (state_q != IDLE));
        restart   = bus.pix_valid && bus.sof;
        cur_col   = restart ? '0 : col_q;
        cur_row   = restart ? '0 : row_q;
        cur_wsel  = restart ? 1'b0 : wsel_q;
        col_wrap  = (cur_col == COL_LAST);
        frame_end = col_wrap && (cur_row == ROW_LAST);
        top_rd    = cur_wsel ? lb1[cur_col] : lb0[cur_col];
        mid_rd    = cur_wsel ? lb0[cur_col] : lb1[cur_col];
    end

    always_comb begin
        state_d = state_q;
        win_d   = 1'b0;
        last_d  = 1'b0;
        done_d  = 1'b0;
        if (restart) begin
            state_d = FILL;
        end else if (accept) begin
            case (state_q)
                FILL: begin
                    if (col_wrap && (cur_row == ROW_ONE)) state_d = RUN;
                end
                RUN: begin
                    win_d  = 1'b1;
                    last_d = col_wrap;
                    if (frame_end) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q  <= '0;
            row_q  <= '0;
            wsel_q <= 1'b0;
            top_q  <= '0;
            mid_q  <= '0;
            bot_q  <= '0;
            win_q  <= 1'b0;
            last_q <= 1'b0;
            done_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            win_q  <= win_d;
            last_q <= last_d;
            done_q <= done_d;
            busy_q <= (state_d != IDLE);
            if (accept) begin
                top_q <= top_rd;
                mid_q <= mid_rd;
                bot_q <= bus.pix_data;
                if (col_wrap) begin
                    col_q  <= '0;
                    row_q  <= (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
                    wsel_q <= ~cur_wsel;
                end else begin
                    col_q  <= cur_col + CW'(1);
                    row_q  <= cur_row;
                    wsel_q <= cur_wsel;
                end
            end
        end
    end

    // Buffer contents are never reset; the bank being overwritten holds line r-2.
    always_ff @(posedge clk) begin
        if (accept) begin
            if (cur_wsel) lb1[cur_col] <= bus.pix_data;
            else          lb0[cur_col] <= bus.pix_data;
        end
    end

    assign bus.row_top    = top_q;
    assign bus.row_mid    = mid_q;
    assign bus.row_bot    = bot_q;
    assign bus.win_valid  = win_q;
    assign bus.line_last  = last_q;
    assign bus.frame_done = done_q;
    assign bus.busy       = busy_q;
    assign bus.dbg_state  = state_q;
endmodule
